ram_stream_loader: RTL and testbench

RAM_STREAM_LOADER -- requirements
Module: ram_stream_loader

---
 rtl/ram_loader_pkg.sv | 21 ++
 rtl/byte_packer.sv | 66 ++++++
 rtl/ram_stream_loader.sv | 230 +++++++++++++++++++++++
 tb/tb_ram_stream_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM stream loader.
//   - RAM_ADDR_W_DEF / RAM_DEPTH_DEF : default word-address width and RAM depth
//   - loader_state_e                 : loader FSM state encoding
//   - be_to_mask()                   : expands a 4-bit byte enable into a 32-bit lane mask
package ram_loader_pkg;

    localparam int RAM_ADDR_W_DEF = 12;
    localparam int RAM_DEPTH_DEF  = 2560;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } loader_state_e;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        be_to_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   clear           : drop any partially packed word (new load starting)
//   byte_valid      : a byte transfers this cycle
//   byte_data       : the byte
//   byte_last       : the byte is the final one of the stream
//   word_done       : this transfer completes a word (4th lane or last byte)
//   word_data       : the completed word, unfilled lanes are zero
//   word_be         : lane mask of the filled lanes of the completed word
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        word_done,
    output logic [31:0] word_data,
    output logic [3:0]  word_be
);

    logic [23:0] acc_r;
    logic [1:0]  lane_r;

    // Lanes 0..top_lane are filled once the byte for top_lane arrives.
    function automatic logic [3:0] lane_mask(input logic [1:0] top_lane);
        case (top_lane)
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            2'd2:    lane_mask = 4'b0111;
            2'd3:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Merge the incoming byte into its lane on top of the bytes already held
    always_comb begin
        word_data = 32'h0000_0000;
        case (lane_r)
            2'd0:    word_data = {24'h00_0000, byte_data};
            2'd1:    word_data = {16'h0000, byte_data, acc_r[7:0]};
            2'd2:    word_data = {8'h00, byte_data, acc_r[15:0]};
            2'd3:    word_data = {byte_data, acc_r};
            default: word_data = 32'h0000_0000;
        endcase
        word_be   = lane_mask(lane_r);
        // A last byte in lane 3 completes exactly one word, never an extra empty one
        word_done = byte_valid & ((lane_r == 2'd3) | byte_last);
    end

    // Hold the partial word between bytes; restart at lane 0 after each emitted word
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_r  <= 24'h00_0000;
            lane_r <= 2'd0;
        end else if (word_done) begin
            acc_r  <= 24'h00_0000;
            lane_r <= 2'd0;
        end else if (byte_valid) begin
            acc_r  <= word_data[23:0];
            lane_r <= lane_r + 2'd1;
        end
    end

endmodule

// File: rtl/ram_stream_loader.sv
// Loads a byte stream into a word RAM starting at base_addr, then reads the
// written region back and accumulates a 32-bit checksum of it.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   start, base_addr                : one-cycle load request and first word address
//   in_data/in_valid/in_last/in_ready : byte stream handshake
//   ram_*                           : RAM master port (1-cycle read latency, no waitrequest)
//   busy, done, err                 : status (done is a one-cycle pulse, err = overflow)
//   word_count, checksum            : words written and checksum of the read-back
module ram_stream_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W_DEF,
    parameter int DEPTH  = RAM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    output logic              ram_clken,
    input  logic [31:0]       ram_readdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] WC_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_e     state_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   wc_r;
    logic [ADDR_W:0]   rd_idx_r;
    logic [31:0]       checksum_r;
    logic              err_r;
    logic              in_ready_r;
    logic              busy_r;
    logic              done_r;
    logic [ADDR_W-1:0] ram_address_r;
    logic [3:0]        ram_byteenable_r;
    logic              ram_chipselect_r;
    logic              ram_write_r;
    logic [31:0]       ram_writedata_r;
    logic [3:0]        last_be_r;
    // Read pipeline: iss_r while an address is on the bus, cap_r while its data returns
    logic              iss_r;
    logic [31:0]       iss_mask_r;
    logic              cap_r;
    logic [31:0]       cap_mask_r;

    logic              xfer_s;
    logic              clear_s;
    logic [ADDR_W:0]   wr_sum_s;
    logic              overflow_s;
    logic              wr_ok_s;
    logic [ADDR_W:0]   wc_next_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              rd_last_s;
    logic [31:0]       rd_mask_s;
    logic              word_done_s;
    logic [31:0]       word_data_s;
    logic [3:0]        word_be_s;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_s),
        .byte_valid (xfer_s),
        .byte_data  (in_data),
        .byte_last  (in_last),
        .word_done  (word_done_s),
        .word_data  (word_data_s),
        .word_be    (word_be_s)
    );

    // Handshake, target-address overflow test and read-back address/mask selection
    always_comb begin
        xfer_s     = (state_r == ST_LOAD) & in_valid & in_ready_r;
        clear_s    = (state_r == ST_IDLE) & start;
        // One bit wider than the address so base+count cannot wrap past DEPTH
        wr_sum_s   = {1'b0, base_r} + wc_r;
        overflow_s = (wr_sum_s >= DEPTH_W);
        wr_ok_s    = word_done_s & ~overflow_s;
        if (wr_ok_s) begin
            wc_next_s = wc_r + WC_ONE;
        end else begin
            wc_next_s = wc_r;
        end
        rd_addr_s = base_r + rd_idx_r[ADDR_W-1:0];
        rd_last_s = (rd_idx_r == (wc_r - WC_ONE));
        // Only the final word can be partial; its unwritten lanes must not count
        if (rd_last_s) begin
            rd_mask_s = be_to_mask(last_be_r);
        end else begin
            rd_mask_s = 32'hFFFF_FFFF;
        end
    end

    // Loader FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            base_r           <= {ADDR_W{1'b0}};
            wc_r             <= {(ADDR_W+1){1'b0}};
            rd_idx_r         <= {(ADDR_W+1){1'b0}};
            checksum_r       <= 32'h0000_0000;
            err_r            <= 1'b0;
            in_ready_r       <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            ram_address_r    <= {ADDR_W{1'b0}};
            ram_byteenable_r <= 4'h0;
            ram_chipselect_r <= 1'b0;
            ram_write_r      <= 1'b0;
            ram_writedata_r  <= 32'h0000_0000;
            last_be_r        <= 4'h0;
            iss_r            <= 1'b0;
            iss_mask_r       <= 32'h0000_0000;
            cap_r            <= 1'b0;
            cap_mask_r       <= 32'h0000_0000;
        end else begin
            ram_chipselect_r <= 1'b0;
            ram_write_r      <= 1'b0;
            done_r           <= 1'b0;
            iss_r            <= 1'b0;
            cap_r            <= iss_r;
            cap_mask_r       <= iss_mask_r;
            if (cap_r) begin
                checksum_r <= checksum_r + (ram_readdata & cap_mask_r);
            end

            case (state_r)
                ST_IDLE: begin
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    if (start) begin
                        base_r     <= base_addr;
                        wc_r       <= {(ADDR_W+1){1'b0}};
                        rd_idx_r   <= {(ADDR_W+1){1'b0}};
                        checksum_r <= 32'h0000_0000;
                        err_r      <= 1'b0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (word_done_s) begin
                        if (overflow_s) begin
                            // Keep accepting bytes so the stream drains to in_last
                            err_r <= 1'b1;
                        end else begin
                            ram_chipselect_r <= 1'b1;
                            ram_write_r      <= 1'b1;
                            ram_address_r    <= wr_sum_s[ADDR_W-1:0];
                            ram_writedata_r  <= word_data_s;
                            ram_byteenable_r <= word_be_s;
                            last_be_r        <= word_be_s;
                            wc_r             <= wc_next_s;
                        end
                    end
                    if (xfer_s && in_last) begin
                        in_ready_r <= 1'b0;
                        rd_idx_r   <= {(ADDR_W+1){1'b0}};
                        if (wc_next_s == {(ADDR_W+1){1'b0}}) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            // The final write goes out while READ issues its first address
                            state_r <= ST_READ;
                        end
                    end
                end

                ST_READ: begin
                    if (rd_idx_r != wc_r) begin
                        ram_chipselect_r <= 1'b1;
                        ram_write_r      <= 1'b0;
                        ram_address_r    <= rd_addr_s;
                        ram_byteenable_r <= 4'hF;
                        iss_r            <= 1'b1;
                        iss_mask_r       <= rd_mask_s;
                        rd_idx_r         <= rd_idx_r + WC_ONE;
                    end else if (!iss_r) begin
                        // Last data is in its capture cycle; it lands together with done
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    busy_r     <= 1'b0;
                    in_ready_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_r;
    assign ram_address    = ram_address_r;
    assign ram_byteenable = ram_byteenable_r;
    assign ram_chipselect = ram_chipselect_r;
    assign ram_write      = ram_write_r;
    assign ram_writedata  = ram_writedata_r;
    assign ram_clken      = 1'b1;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;
    assign word_count     = wc_r;
    assign checksum       = checksum_r;

endmodule

// File: tb/tb_ram_stream_loader.sv
// Self-checking bench for ram_stream_loader: a behavioural RAM, a write/done
// monitor and a byte-list reference model of the expected writes and results.
module tb_ram_stream_loader;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 2560;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_address;
    logic [3:0]        ram_byteenable;
    logic              ram_chipselect;
    logic              ram_write;
    logic [31:0]       ram_writedata;
    logic              ram_clken;
    logic [31:0]       ram_readdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       checksum;

    always #5 clk = ~clk;

    ram_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .word_count     (word_count),
        .checksum       (checksum)
    );

    // Byte-enabled RAM with one cycle of read latency
    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_chipselect && ram_write) begin
            for (int l = 0; l < 4; l++) begin
                if (ram_byteenable[l]) mem[ram_address][8*l +: 8] <= ram_writedata[8*l +: 8];
            end
        end
        if (ram_chipselect) ram_readdata <= mem[ram_address];
    end

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wr_t;

    wr_t wr_log[$];
    int  done_cnt = 0;

    // Log every RAM write and every done pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (ram_chipselect === 1'b1 && ram_write === 1'b1)
            wr_log.push_back('{ram_address, ram_writedata, ram_byteenable});
        if (done === 1'b1) done_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] lane_bits(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int k = 0; k < 4; k++) if (be[k]) m[8*k +: 8] = 8'hFF;
        return m;
    endfunction

    // Reference model: chop the byte list into 4-byte words, drop words past the RAM end
    logic [7:0]      tx_q[$];
    wr_t             exp_q[$];
    logic [ADDR_W:0] exp_wc;
    logic [31:0]     exp_sum;
    logic            exp_err;

    task automatic build_model(input int base);
        int nw;
        logic [31:0] d;
        logic [3:0]  be;
        exp_q.delete();
        exp_wc  = '0;
        exp_sum = 32'h0;
        exp_err = 1'b0;
        nw = (tx_q.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            d  = 32'h0;
            be = 4'h0;
            for (int k = 0; k < 4; k++) begin
                if (4*w + k < tx_q.size()) begin
                    d[8*k +: 8] = tx_q[4*w + k];
                    be[k] = 1'b1;
                end
            end
            if (base + w >= DEPTH) exp_err = 1'b1;
            else begin
                exp_q.push_back('{ADDR_W'(base + w), d, be});
                exp_wc  = exp_wc + 1'b1;
                exp_sum = exp_sum + d;
            end
        end
    endtask

    task automatic fill_random(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(1, 255)));
    endtask

    task automatic run_case(input string name, input int base, input bit stall, input bit dbl);
        int idx, guard, cyc, wr0, dn0;
        build_model(base);
        wr0 = wr_log.size();
        dn0 = done_cnt;
        @(negedge clk); start = 1'b1; base_addr = ADDR_W'(base);
        @(negedge clk); start = 1'b0;
        check({name, "_busy_load"}, busy, 1);
        idx = 0; guard = 0;
        while (idx < tx_q.size() && guard < 1000) begin
            @(negedge clk);
            guard++;
            start = dbl && (idx == 2);
            if (dbl) base_addr = ADDR_W'(base + 37);
            if (stall && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0; in_last = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = tx_q[idx];
                in_last  = (idx == tx_q.size() - 1);
                if (in_ready) idx++;
            end
        end
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        check({name, "_bytes_accepted"}, idx, tx_q.size());
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        check({name, "_done_seen"}, done, 1);
        check({name, "_word_count"}, word_count, exp_wc);
        check({name, "_checksum"}, checksum, exp_sum);
        check({name, "_err"}, err, exp_err);
        @(negedge clk);
        @(negedge clk);
        check({name, "_idle_after"}, {busy, done, in_ready}, 0);
        check({name, "_done_pulses"}, done_cnt - dn0, 1);
        check({name, "_results_hold"}, {word_count, checksum}, {exp_wc, exp_sum});
        check({name, "_nwrites"}, wr_log.size() - wr0, exp_q.size());
        for (int i = 0; i < exp_q.size() && wr0 + i < wr_log.size(); i++) begin
            check({name, "_wr_addr"}, wr_log[wr0+i].addr, exp_q[i].addr);
            check({name, "_wr_be"}, wr_log[wr0+i].be, exp_q[i].be);
            check({name, "_wr_data"}, wr_log[wr0+i].data & lane_bits(exp_q[i].be), exp_q[i].data);
        end
    endtask

    initial begin
        int wr0;
        reset = 1'b1; start = 1'b0; base_addr = '0;
        in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {in_ready, busy, done, err, ram_chipselect, ram_write, ram_byteenable}, 0);
        check("reset_addr_wc", {ram_address, word_count}, 0);
        check("reset_data_sum", {ram_writedata, checksum}, 0);
        check("reset_clken", ram_clken, 1);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);

        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_case("two_words", 0, 1'b0, 1'b0);

        // Leave non-zero bytes at address 10 so a partial write there leaves stale lanes
        fill_random(16);
        run_case("prime", 8, 1'b0, 1'b0);

        tx_q = '{8'hAA, 8'hBB, 8'hCC};
        run_case("partial", 10, 1'b0, 1'b0);

        fill_random(12);
        run_case("overflow", 2558, 1'b1, 1'b0);

        fill_random(3);
        run_case("all_overflow", 3000, 1'b0, 1'b0);

        fill_random(10);
        run_case("double_start", 40, 1'b1, 1'b1);

        // Reset while a load is in flight
        fill_random(5);
        @(negedge clk); start = 1'b1; base_addr = ADDR_W'(20);
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = tx_q[i]; in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        wr0 = wr_log.size();
        @(negedge clk);
        check("midrst_ctrl", {in_ready, busy, done, err, ram_chipselect, ram_write, ram_byteenable}, 0);
        check("midrst_addr_wc", {ram_address, word_count}, 0);
        check("midrst_data_sum", {ram_writedata, checksum}, 0);
        reset = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("midrst_no_write", wr_log.size() - wr0, 0);
        check("midrst_in_ready", in_ready, 0);
        fill_random(7);
        run_case("after_reset", 50, 1'b0, 1'b0);

        fill_random(9);
        run_case("stalled_nine", 100, 1'b1, 1'b0);
        check("stalled_nine_last_be", wr_log[wr_log.size()-1].be, 4'b0001);

        for (int r = 0; r < 3; r++) begin
            fill_random($urandom_range(1, 20));
            run_case("random", $urandom_range(200, DEPTH - 30), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
